// File: rtl/bullet_ctrl_if.sv
// Bundle between a tank's fire/position signals, the maze contact logic and one bullet controller.
interface bullet_ctrl_if;
    logic       shoot;
    logic [7:0] sin;
    logic [7:0] cos;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic       isWallLeft;
    logic       isWallRight;
    logic       isWallTop;
    logic       isWallBottom;
    logic       hit;
    logic [1:0] game_end;
    logic [9:0] BulletX;
    logic [9:0] BulletY;
    logic [9:0] BulletS;
    logic       bullet_active;
    logic       ready;

    modport master (
        output shoot, sin, cos, tank_x, tank_y,
        output isWallLeft, isWallRight, isWallTop, isWallBottom, hit, game_end,
        input  BulletX, BulletY, BulletS, bullet_active, ready
    );

    modport slave (
        input  shoot, sin, cos, tank_x, tank_y,
        input  isWallLeft, isWallRight, isWallTop, isWallBottom, hit, game_end,
        output BulletX, BulletY, BulletS, bullet_active, ready
    );
endinterface

// File: rtl/bullet_ctrl.sv
// One tank's bullet: spawns ahead of the tank on a shoot rise, flies in 10.3 fixed point,
// reflects off maze walls and retires on hit, lifetime, bounce limit, screen exit or game end.
module bullet_ctrl #(
    parameter int BULLET_STEP = 24,
    parameter int SPAWN_DIST  = 12,
    parameter int LIFETIME    = 300,
    parameter int MAX_BOUNCE  = 5,
    parameter int COOLDOWN    = 30,
    parameter int BULLET_SIZE = 2
) (
    input logic          frame_clk,
    input logic          Reset,
    bullet_ctrl_if.slave bus
);
    localparam int LW = (LIFETIME   > 1) ? $clog2(LIFETIME + 1)   : 1;
    localparam int BW = (MAX_BOUNCE > 1) ? $clog2(MAX_BOUNCE + 1) : 1;
    localparam int CW = (COOLDOWN   > 1) ? $clog2(COOLDOWN + 1)   : 1;

    typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

    state_t      state;
    logic        shoot_d;
    logic [12:0] px_q, py_q;
    logic        sx, sy;
    logic [7:0]  vmx, vmy;
    logic [LW-1:0] life;
    logic [BW-1:0] bounces;
    logic [CW-1:0] cool_cnt;
    logic        active_q, ready_q;

    logic        fire;
    logic [7:0]  vmx_new, vmy_new, offx, offy;
    logic [12:0] spawn_x, spawn_y;
    logic        flip_x, flip_y, nsx, nsy;
    logic [BW-1:0] bounce_next;
    logic [13:0] x_sum, y_sum;
    logic        x_out, y_out;
    logic [12:0] nx, ny;
    logic        fly_retire;

    // Spawn geometry and per-frame velocity come straight from the tank's current heading.
    always_comb begin
        fire    = bus.shoot & ~shoot_d;
        vmx_new = 8'((15'(BULLET_STEP) * 15'(bus.cos[6:0])) >> 7);
        vmy_new = 8'((15'(BULLET_STEP) * 15'(bus.sin[6:0])) >> 7);
        offx    = 8'((15'(SPAWN_DIST) * 15'(bus.cos[6:0])) >> 7);
        offy    = 8'((15'(SPAWN_DIST) * 15'(bus.sin[6:0])) >> 7);
        spawn_x = bus.cos[7] ? ({bus.tank_x, 3'b000} - 13'({offx, 3'b000}))
                             : ({bus.tank_x, 3'b000} + 13'({offx, 3'b000}));
        spawn_y = ~bus.sin[7] ? ({bus.tank_y, 3'b000} - 13'({offy, 3'b000}))
                              : ({bus.tank_y, 3'b000} + 13'({offy, 3'b000}));
    end

    // A wall only reflects when the bullet is heading into it; the move uses the reflected signs.
    always_comb begin
        flip_x      = (bus.isWallLeft & sx) | (bus.isWallRight & ~sx);
        flip_y      = (bus.isWallTop & sy) | (bus.isWallBottom & ~sy);
        nsx         = sx ^ flip_x;
        nsy         = sy ^ flip_y;
        bounce_next = bounces + BW'(1);
        x_sum       = {1'b0, px_q} + 14'(vmx);
        y_sum       = {1'b0, py_q} + 14'(vmy);
        x_out       = nsx ? (px_q < 13'(vmx)) : (x_sum[13:3] > 11'd639);
        y_out       = nsy ? (py_q < 13'(vmy)) : (y_sum[13:3] > 11'd479);
        nx          = nsx ? (px_q - 13'(vmx)) : x_sum[12:0];
        ny          = nsy ? (py_q - 13'(vmy)) : y_sum[12:0];
        fly_retire  = bus.hit | (life == LW'(1)) |
                      ((flip_x | flip_y) & (bounce_next == BW'(MAX_BOUNCE))) |
                      x_out | y_out;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state    <= IDLE;
            shoot_d  <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            sx       <= 1'b0;
            sy       <= 1'b0;
            vmx      <= '0;
            vmy      <= '0;
            life     <= '0;
            bounces  <= '0;
            cool_cnt <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            shoot_d <= bus.shoot;
            case (state)
                IDLE: begin
                    if (fire && bus.game_end == 2'b00) begin
                        state    <= FLY;
                        sx       <= bus.cos[7];
                        sy       <= ~bus.sin[7];
                        vmx      <= vmx_new;
                        vmy      <= vmy_new;
                        px_q     <= spawn_x;
                        py_q     <= spawn_y;
                        life     <= LW'(LIFETIME);
                        bounces  <= '0;
                        active_q <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                FLY: begin
                    if (bus.game_end != 2'b00) begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else if (fly_retire) begin
                        // Every retire reason lands in COOL with the position left untouched.
                        state    <= COOL;
                        active_q <= 1'b0;
                        cool_cnt <= CW'(COOLDOWN);
                    end else begin
                        life <= life - LW'(1);
                        if (flip_x | flip_y)
                            bounces <= bounce_next;
                        sx   <= nsx;
                        sy   <= nsy;
                        px_q <= nx;
                        py_q <= ny;
                    end
                end
                COOL: begin
                    if (bus.game_end != 2'b00 || cool_cnt <= CW'(1)) begin
                        state    <= IDLE;
                        cool_cnt <= '0;
                        ready_q  <= 1'b1;
                    end else begin
                        cool_cnt <= cool_cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.BulletX       = px_q[12:3];
    assign bus.BulletY       = py_q[12:3];
    assign bus.BulletS       = 10'(BULLET_SIZE);
    assign bus.bullet_active = active_q;
    assign bus.ready         = ready_q;
endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed scoreboard bench for bullet_ctrl; a second instance with SPAWN_DIST=0 covers the left-edge exit.
module tb_bullet_ctrl;
    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       shoot;
    logic [7:0] sin_v, cos_v;
    logic [9:0] tx, ty;
    logic       wl, wr, wt, wb, hit;
    logic [1:0] game_end;

    bullet_ctrl_if bus();
    bullet_ctrl_if bus0();

    assign bus.shoot = shoot;         assign bus0.shoot = shoot;
    assign bus.sin = sin_v;           assign bus0.sin = sin_v;
    assign bus.cos = cos_v;           assign bus0.cos = cos_v;
    assign bus.tank_x = tx;           assign bus0.tank_x = tx;
    assign bus.tank_y = ty;           assign bus0.tank_y = ty;
    assign bus.isWallLeft = wl;       assign bus0.isWallLeft = wl;
    assign bus.isWallRight = wr;      assign bus0.isWallRight = wr;
    assign bus.isWallTop = wt;        assign bus0.isWallTop = wt;
    assign bus.isWallBottom = wb;     assign bus0.isWallBottom = wb;
    assign bus.hit = hit;             assign bus0.hit = hit;
    assign bus.game_end = game_end;   assign bus0.game_end = game_end;

    bullet_ctrl dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));
    bullet_ctrl #(.SPAWN_DIST(0)) dut0 (.frame_clk(frame_clk), .Reset(Reset), .bus(bus0));

    always #5 frame_clk = ~frame_clk;

    localparam int K_X = 0, K_Y = 1, K_ACT = 2, K_RDY = 3, K_S = 4, K_X0 = 5, K_ACT0 = 6;

    typedef struct {
        string      tag;
        int         kind;
        logic [9:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expectVal(input string tag, input int kind, input logic [9:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic r, input logic t,
                                 input logic h, input logic [1:0] ge);
        shoot    = s;
        wl       = l;
        wr       = r;
        wt       = t;
        wb       = 1'b0;
        hit      = h;
        game_end = ge;
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [9:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_X:     obs = bus.BulletX;
                K_Y:     obs = bus.BulletY;
                K_ACT:   obs = {9'd0, bus.bullet_active};
                K_RDY:   obs = {9'd0, bus.ready};
                K_S:     obs = bus.BulletS;
                K_X0:    obs = bus0.BulletX;
                default: obs = {9'd0, bus0.bullet_active};
            endcase
            total++;
            assert (obs === e.val)
            else begin
                bad++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic frame();
        @(posedge frame_clk);
        #1;
        checkOutput();
    endtask

    initial begin
        Reset = 1'b0;
        cos_v = 8'h7F;
        sin_v = 8'h00;
        tx    = 10'd100;
        ty    = 10'd200;
        applyStimulus(0, 0, 0, 0, 0, 2'd0);

        frame();
        expectVal("reset_x", K_X, 10'd0);
        expectVal("reset_y", K_Y, 10'd0);
        expectVal("reset_active", K_ACT, 10'd0);
        expectVal("reset_ready", K_RDY, 10'd1);
        expectVal("size", K_S, 10'd2);
        frame();

        Reset = 1'b1;
        expectVal("idle_ready", K_RDY, 10'd1);
        frame();

        $display("[TB] straight shot");
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("spawn_x", K_X, 10'd111);
        expectVal("spawn_y", K_Y, 10'd200);
        expectVal("spawn_active", K_ACT, 10'd1);
        expectVal("spawn_ready", K_RDY, 10'd0);
        frame();
        for (int i = 1; i <= 19; i++) begin
            if (i == 8) expectVal("move8_x", K_X, 10'd134);
            if (i == 19) begin
                expectVal("held_x", K_X, 10'd165);
                expectVal("held_active", K_ACT, 10'd1);
            end
            frame();
        end

        $display("[TB] reflection");
        applyStimulus(0, 1, 0, 0, 0, 2'd0);
        expectVal("left_ignored_x", K_X, 10'd168);
        frame();
        applyStimulus(0, 0, 1, 0, 0, 2'd0);
        expectVal("right_flip_x", K_X, 10'd165);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        expectVal("after_flip_x", K_X, 10'd162);
        frame();

        applyStimulus(0, 0, 0, 0, 0, 2'd1);
        expectVal("gameend_active", K_ACT, 10'd0);
        expectVal("gameend_ready", K_RDY, 10'd1);
        expectVal("gameend_hold_x", K_X, 10'd162);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        expectVal("no_cooldown_ready", K_RDY, 10'd1);
        frame();

        $display("[TB] bounce limit");
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("b_spawn_x", K_X, 10'd111);
        expectVal("b_spawn_active", K_ACT, 10'd1);
        frame();
        for (int b = 1; b <= 5; b++) begin
            applyStimulus(0, (b % 2) == 0, (b % 2) == 1, 0, 0, 2'd0);
            expectVal($sformatf("bounce%0d_x", b), K_X, (b % 2 == 1 && b < 5) ? 10'd108 : 10'd111);
            expectVal($sformatf("bounce%0d_active", b), K_ACT, (b < 5) ? 10'd1 : 10'd0);
            frame();
        end
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(i == 10, 0, 0, 0, 0, 2'd0);
            if (i == 10) begin
                expectVal("cool_shot_ignored", K_ACT, 10'd0);
                expectVal("cool_hold_x", K_X, 10'd111);
            end
            if (i == 29) expectVal("cool29_ready", K_RDY, 10'd0);
            if (i == 30) expectVal("cool30_ready", K_RDY, 10'd1);
            frame();
        end
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        expectVal("not_queued_active", K_ACT, 10'd0);
        frame();

        $display("[TB] hit beats wall");
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("h_spawn_active", K_ACT, 10'd1);
        frame();
        applyStimulus(0, 0, 0, 1, 1, 2'd0);
        expectVal("hit_active", K_ACT, 10'd0);
        expectVal("hit_ready", K_RDY, 10'd0);
        expectVal("hit_hold_x", K_X, 10'd111);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd2);
        expectVal("cool_gameend_ready", K_RDY, 10'd1);
        frame();

        $display("[TB] lifetime");
        cos_v = 8'h00;
        sin_v = 8'h00;
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("l_spawn_x", K_X, 10'd100);
        expectVal("l_spawn_y", K_Y, 10'd200);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        for (int k = 1; k <= 300; k++) begin
            if (k == 299) expectVal("life299_active", K_ACT, 10'd1);
            if (k == 300) begin
                expectVal("life300_active", K_ACT, 10'd0);
                expectVal("life_hold_x", K_X, 10'd100);
            end
            frame();
        end

        $display("[TB] left screen exit");
        Reset = 1'b0;
        frame();
        Reset = 1'b1;
        tx    = 10'd2;
        ty    = 10'd100;
        cos_v = 8'hFF;
        frame();
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("exit_spawn_x", K_X0, 10'd2);
        expectVal("exit_spawn_active", K_ACT0, 10'd1);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        expectVal("exit_active", K_ACT0, 10'd0);
        expectVal("exit_hold_x", K_X0, 10'd2);
        frame();
        expectVal("exit_still_x", K_X0, 10'd2);
        frame();

        $display("[TB] right screen exit");
        applyStimulus(0, 0, 0, 0, 0, 2'd1);
        frame();
        tx    = 10'd620;
        ty    = 10'd200;
        cos_v = 8'h7F;
        applyStimulus(1, 0, 0, 0, 0, 2'd0);
        expectVal("r_spawn_x", K_X, 10'd631);
        expectVal("r_spawn_active", K_ACT, 10'd1);
        frame();
        applyStimulus(0, 0, 0, 0, 0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                expectVal("r_edge_x", K_X, 10'd639);
                expectVal("r_edge_active", K_ACT, 10'd1);
            end
            if (k == 4) begin
                expectVal("r_exit_active", K_ACT, 10'd0);
                expectVal("r_exit_hold_x", K_X, 10'd639);
            end
            frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
